// File: rtl/alu16_pipe_if.sv
// Handshake/bus bundle for alu16_pipe: operand side, result side and, with ALU_OVF_EN, the sticky overflow pair.
interface alu16_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             zx;
  logic             nx;
  logic             zy;
  logic             ny;
  logic             f;
  logic             no;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
`ifdef ALU_OVF_EN
  logic             ovf;
  logic             ovf_clr;
`endif

  modport slave (
    input  in_valid, x, y, zx, nx, zy, ny, f, no, out_ready,
`ifdef ALU_OVF_EN
    input  ovf_clr,
    output ovf,
`endif
    output in_ready, out_valid, out, zr, ng
  );

  modport master (
    output in_valid, x, y, zx, nx, zy, ny, f, no, out_ready,
`ifdef ALU_OVF_EN
    output ovf_clr,
    input  ovf,
`endif
    input  in_ready, out_valid, out, zr, ng
  );
endinterface

// File: rtl/alu16_pipe.sv
// Two-stage Hack-style ALU with valid/ready on both sides; stage 1 preconditions operands, stage 2 computes.
// Optional sticky signed-overflow flag enabled by defining ALU_OVF_EN.
module alu16_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  alu16_pipe_if.slave  bus
);
  localparam int unsigned MSB = WIDTH - 1;

  // Pipeline occupancy: bit 0 = stage 1 full, bit 1 = stage 2 full.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    S1    = 2'b01,
    S2    = 2'b10,
    BOTH  = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             w_s1_valid;
  logic             w_s2_valid;
  logic             w_s1_ready;
  logic             w_s2_ready;
  logic             w_accept;
  logic             w_advance;

  logic [WIDTH-1:0] w_xz;
  logic [WIDTH-1:0] w_yz;
  logic [WIDTH-1:0] w_x1;
  logic [WIDTH-1:0] w_y1;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_raw;
  logic [WIDTH-1:0] w_res;

  logic [WIDTH-1:0] r_x1;
  logic [WIDTH-1:0] r_y1;
  logic             r_f1;
  logic             r_no1;
  logic [WIDTH-1:0] r_out;
  logic             r_zr;
  logic             r_ng;

  assign w_s1_valid = r_state[0];
  assign w_s2_valid = r_state[1];
  assign w_s2_ready = !w_s2_valid || bus.out_ready;
  assign w_s1_ready = !w_s1_valid || w_s2_ready;
  assign w_accept   = bus.in_valid && w_s1_ready;
  assign w_advance  = w_s1_valid && w_s2_ready;

  assign bus.in_ready  = w_s1_ready;
  assign bus.out_valid = w_s2_valid;
  assign bus.out       = r_out;
  assign bus.zr        = r_zr;
  assign bus.ng        = r_ng;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: begin
        if (w_accept) w_state_nxt = S1;
      end
      S1: begin
        w_state_nxt = w_accept ? BOTH : S2;
      end
      S2: begin
        if (bus.out_ready) w_state_nxt = w_accept ? S1 : EMPTY;
        else if (w_accept) w_state_nxt = BOTH;
      end
      BOTH: begin
        if (bus.out_ready) w_state_nxt = w_accept ? BOTH : S2;
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Stage 1 operand preconditioning: zero first, then negate.
  assign w_xz = bus.zx ? '0 : bus.x;
  assign w_yz = bus.zy ? '0 : bus.y;
  assign w_x1 = bus.nx ? ~w_xz : w_xz;
  assign w_y1 = bus.ny ? ~w_yz : w_yz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x1  <= '0;
      r_y1  <= '0;
      r_f1  <= 1'b0;
      r_no1 <= 1'b0;
    end else if (w_accept) begin
      r_x1  <= w_x1;
      r_y1  <= w_y1;
      r_f1  <= bus.f;
      r_no1 <= bus.no;
    end
  end

  assign w_sum = r_x1 + r_y1;
  assign w_raw = r_f1 ? w_sum : (r_x1 & r_y1);
  assign w_res = r_no1 ? ~w_raw : w_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out <= '0;
      r_zr  <= 1'b0;
      r_ng  <= 1'b0;
    end else if (w_advance) begin
      r_out <= w_res;
      r_zr  <= (w_res == '0);
      r_ng  <= w_res[MSB];
    end
  end

`ifdef ALU_OVF_EN
  logic w_ovf_cand;
  logic w_emit;
  logic r_ovf_cand2;
  logic r_ovf;

  assign w_ovf_cand = r_f1 && (r_x1[MSB] == r_y1[MSB]) && (w_sum[MSB] != r_x1[MSB]);
  assign w_emit     = w_s2_valid && bus.out_ready;
  assign bus.ovf    = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cand2 <= 1'b0;
    end else if (w_advance) begin
      r_ovf_cand2 <= w_ovf_cand;
    end
  end

  // Sticky flag sets when an overflowing add leaves stage 2; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (bus.ovf_clr) begin
      r_ovf <= 1'b0;
    end else if (w_emit && r_ovf_cand2) begin
      r_ovf <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_alu16_pipe.sv
// Self-checking bench for alu16_pipe: vector table, scoreboard-checked streaming, backpressure and reset sequences.
module tb_alu16_pipe;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        zx;
    logic        nx;
    logic        zy;
    logic        ny;
    logic        f;
    logic        no;
  } op_t;

  typedef struct packed {
    logic [15:0] out;
    logic        zr;
    logic        ng;
    logic        ovf;
    logic [31:0] cyc;
  } exp_t;

  typedef struct {
    op_t         op;
    logic [15:0] out;
    logic        zr;
    logic        ng;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu16_pipe_if #(.WIDTH(16)) bus ();
  alu16_pipe #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int          checks = 0;
  int          failures = 0;
  op_t         pend[$];
  exp_t        sb[$];
  logic [31:0] cyc = 0;
  bit          rand_rdy = 1'b0;
  bit          rdy_val = 1'b1;
  bit          chk_lat = 1'b0;
  int          n_out = 0;
  logic [15:0] got_out;
  logic        got_zr;
  logic        got_ng;
  bit          stalled_prev = 1'b0;
  logic [17:0] held;
  bit          tb_ovf = 1'b0;
  vec_t        tbl[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  function automatic op_t mkop(input logic [15:0] x, input logic [15:0] y, input logic zx, input logic nx,
                               input logic zy, input logic ny, input logic f, input logic no);
    op_t o;
    o.x = x; o.y = y; o.zx = zx; o.nx = nx; o.zy = zy; o.ny = ny; o.f = f; o.no = no;
    return o;
  endfunction

  function automatic op_t rand_op();
    return mkop(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endfunction

  // Golden Hack ALU.
  function automatic exp_t model(input op_t o);
    logic [15:0] a, b, s, r;
    exp_t e;
    a = o.zx ? 16'h0000 : o.x;
    if (o.nx) a = ~a;
    b = o.zy ? 16'h0000 : o.y;
    if (o.ny) b = ~b;
    s = a + b;
    r = o.f ? s : (a & b);
    if (o.no) r = ~r;
    e.out = r;
    e.zr  = (r == 16'h0000);
    e.ng  = r[15];
    e.ovf = o.f && (a[15] == b[15]) && (s[15] != a[15]);
    e.cyc = 32'h0;
    return e;
  endfunction

  task automatic drive_inputs();
    op_t o;
    if (pend.size() > 0) begin
      o = pend[0];
      bus.in_valid = 1'b1;
    end else begin
      o = rand_op();
      bus.in_valid = 1'b0;
    end
    bus.x = o.x; bus.y = o.y; bus.zx = o.zx; bus.nx = o.nx;
    bus.zy = o.zy; bus.ny = o.ny; bus.f = o.f; bus.no = o.no;
  endtask

  // One clock: observe handshakes at negedge, then drive the next cycle's inputs just after posedge.
  task automatic cycle();
    exp_t e;
    bit   fire;
    @(negedge clk);
    cyc++;
    if (stalled_prev) chk("stall_hold", 32'({bus.out, bus.zr, bus.ng}), 32'(held));
`ifdef ALU_OVF_EN
    chk("ovf_flag", 32'(bus.ovf), 32'(tb_ovf));
`endif
    if (bus.in_valid && bus.in_ready) begin
      e = model(pend[0]);
      e.cyc = cyc;
      sb.push_back(e);
      pend.delete(0);
    end
    fire = bus.out_valid && bus.out_ready;
    e = '0;
    if (fire) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output got=0x%0h exp=none", bus.out);
      end else begin
        e = sb.pop_front();
        chk("out", 32'(bus.out), 32'(e.out));
        chk("zr", 32'(bus.zr), 32'(e.zr));
        chk("ng", 32'(bus.ng), 32'(e.ng));
        if (chk_lat) chk("latency", cyc - e.cyc, 32'h2);
        got_out = bus.out;
        got_zr  = bus.zr;
        got_ng  = bus.ng;
        n_out++;
      end
    end
`ifdef ALU_OVF_EN
    if (bus.ovf_clr) tb_ovf = 1'b0;
    else if (fire && e.ovf) tb_ovf = 1'b1;
`endif
    stalled_prev = bus.out_valid && !bus.out_ready;
    held = {bus.out, bus.zr, bus.ng};
    @(posedge clk);
    #1;
    bus.out_ready = rand_rdy ? 1'($urandom) : rdy_val;
    drive_inputs();
  endtask

  task automatic drain(input int budget, input string name);
    int k;
    k = 0;
    while ((sb.size() > 0 || pend.size() > 0) && k < budget) begin
      cycle();
      k++;
    end
    if (sb.size() > 0 || pend.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout got=%0d pending exp=0", name, sb.size() + pend.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    exp_t e;
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
`ifdef ALU_OVF_EN
    bus.ovf_clr = 1'b0;
`endif
    drive_inputs();

    tbl[0] = '{mkop(16'h1234, 16'h5678, 1, 0, 1, 0, 1, 0), 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{mkop(16'h0005, 16'h0003, 0, 0, 0, 0, 1, 0), 16'h0008, 1'b0, 1'b0};
    tbl[2] = '{mkop(16'hABCD, 16'h1111, 1, 1, 1, 0, 1, 0), 16'hFFFF, 1'b0, 1'b1};
    tbl[3] = '{mkop(16'h00FF, 16'h1234, 0, 0, 1, 1, 0, 1), 16'hFF00, 1'b0, 1'b1};
    tbl[4] = '{mkop(16'h0007, 16'h0003, 0, 1, 0, 0, 1, 1), 16'h0004, 1'b0, 1'b0};
    tbl[5] = '{mkop(16'h0010, 16'h9999, 0, 1, 1, 1, 1, 1), 16'h0011, 1'b0, 1'b0};
    tbl[6] = '{mkop(16'h00F0, 16'h0F00, 0, 1, 0, 1, 0, 1), 16'h0FF0, 1'b0, 1'b0};
    tbl[7] = '{mkop(16'hFFFF, 16'h0001, 0, 0, 0, 0, 1, 0), 16'h0000, 1'b1, 1'b0};

    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out", 32'(bus.out), 32'h0);
    chk("rst_zr", 32'(bus.zr), 32'h0);
    chk("rst_ng", 32'(bus.ng), 32'h0);
`ifdef ALU_OVF_EN
    chk("rst_ovf", 32'(bus.ovf), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);

    // Directed vectors, one at a time, with latency check.
    chk_lat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pend.push_back(tbl[i].op);
      drive_inputs();
      n0 = n_out;
      for (int k = 0; k < 8 && n_out == n0; k++) cycle();
      if (n_out == n0) begin
        checks++;
        failures++;
        $display("FAIL vec%0d_timeout got=no_output exp=output", i);
      end else begin
        chk($sformatf("vec%0d_out", i), 32'(got_out), 32'(tbl[i].out));
        chk($sformatf("vec%0d_zr", i), 32'(got_zr), 32'(tbl[i].zr));
        chk($sformatf("vec%0d_ng", i), 32'(got_ng), 32'(tbl[i].ng));
      end
    end

    // Back-to-back without backpressure: every op must keep latency 2.
    for (int i = 0; i < 10; i++) pend.push_back(rand_op());
    drive_inputs();
    drain(30, "stream_full_rate");
    chk_lat = 1'b0;

    // Backpressure: two ops fill the pipe, third is blocked, output holds op1.
    rdy_val = 1'b0;
    bus.out_ready = 1'b0;
    pend.push_back(mkop(16'h0001, 16'h0002, 0, 0, 0, 0, 1, 0));
    pend.push_back(mkop(16'h0F0F, 16'h00FF, 0, 0, 0, 0, 0, 0));
    pend.push_back(mkop(16'h1000, 16'h0234, 0, 0, 0, 0, 1, 0));
    drive_inputs();
    n0 = n_out;
    repeat (4) cycle();
    chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
    chk("bp_accepted", 32'(pend.size()), 32'h1);
    chk("bp_out_valid", 32'(bus.out_valid), 32'h1);
    chk("bp_out_op1", 32'(bus.out), 32'h0003);
    rdy_val = 1'b1;
    bus.out_ready = 1'b1;
    drain(20, "bp");
    chk("bp_count", 32'(n_out - n0), 32'h3);
    chk("bp_last", 32'(got_out), 32'h1234);

    // Random streaming with random backpressure.
    rand_rdy = 1'b1;
    n0 = n_out;
    for (int i = 0; i < 100; i++) pend.push_back(rand_op());
    drive_inputs();
    drain(2000, "random");
    chk("random_count", 32'(n_out - n0), 32'd100);
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;

    // Reset with both stages full.
    rdy_val = 1'b0;
    bus.out_ready = 1'b0;
    pend.push_back(mkop(16'h0101, 16'h0202, 0, 0, 0, 0, 1, 0));
    pend.push_back(mkop(16'h0303, 16'h0404, 0, 0, 0, 0, 1, 0));
    drive_inputs();
    repeat (4) cycle();
    chk("prerst_out_valid", 32'(bus.out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("midrst_out", 32'(bus.out), 32'h0);
    chk("midrst_zr", 32'(bus.zr), 32'h0);
    sb.delete();
    pend.delete();
    stalled_prev = 1'b0;
    tb_ovf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rdy_val = 1'b1;
    bus.out_ready = 1'b1;
    chk("postrst_in_ready", 32'(bus.in_ready), 32'h1);
    pend.push_back(mkop(16'h0001, 16'h0002, 0, 0, 0, 0, 1, 0));
    drive_inputs();
    n0 = n_out;
    repeat (6) cycle();
    chk("postrst_single", 32'(n_out - n0), 32'h1);
    chk("postrst_out", 32'(got_out), 32'h0003);

`ifdef ALU_OVF_EN
    pend.push_back(mkop(16'h7FFF, 16'h0001, 0, 0, 0, 0, 1, 0));
    drive_inputs();
    e = model(pend[0]);
    drain(10, "ovf");
    chk("ovf_op_out", 32'(got_out), 32'h8000);
    chk("ovf_op_ng", 32'(got_ng), 32'(e.ng));
    repeat (3) cycle();
    chk("ovf_sticky", 32'(bus.ovf), 32'h1);
    bus.ovf_clr = 1'b1;
    cycle();
    bus.ovf_clr = 1'b0;
    cycle();
    chk("ovf_cleared", 32'(bus.ovf), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
